// File: rtl/race_pkg.sv
// Shared encodings and constants for the six-lane race controller.
// The LFSR constants are consumed only when RACE_SPEED_JITTER_EN is defined.
package race_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COUNTDOWN = 2'd1;
  localparam logic [1:0] ST_RACE      = 2'd2;
  localparam logic [1:0] ST_FINISH    = 2'd3;

  localparam logic [1:0] LIGHT_OFF = 2'd0;
  localparam logic [1:0] LIGHT_1   = 2'd1;
  localparam logic [1:0] LIGHT_2   = 2'd2;
  localparam logic [1:0] LIGHT_3   = 2'd3;

  localparam int unsigned CAR_W_DEFAULT = 60;
  localparam int unsigned WINNER_W      = 3;

  // Fibonacci LFSR, taps 16,14,13,11 expressed as a bit mask on [15:0]
  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/race_controller_if.sv
// Control/status bundle between the video timing side and the race controller.
interface race_controller_if #(
  parameter int unsigned NUM_CARS = 6,
  parameter int unsigned POS_W    = 16,
  parameter int unsigned SPEED_W  = 4
);
  import race_pkg::*;

  logic                          i_frame_tick;
  logic                          i_start;
  logic                          i_abort;
  logic [11:0]                   H_RES;
  logic [NUM_CARS*SPEED_W-1:0]   i_speed;
  logic [NUM_CARS*POS_W-1:0]     o_car_x;
  logic [1:0]                    o_state;
  logic [1:0]                    o_light;
  logic [WINNER_W-1:0]           o_winner;
  logic                          o_winner_valid;
  logic                          o_tie;

  modport master (
    output i_frame_tick, i_start, i_abort, H_RES, i_speed,
    input  o_car_x, o_state, o_light, o_winner, o_winner_valid, o_tie
  );

  modport slave (
    input  i_frame_tick, i_start, i_abort, H_RES, i_speed,
    output o_car_x, o_state, o_light, o_winner, o_winner_valid, o_tie
  );
endinterface

// File: rtl/race_controller_car_stepper.sv
// Per-lane position step: advance by step, saturate at the finish line, flag crossing.
module car_stepper
  import race_pkg::*;
#(
  parameter int unsigned POS_W  = 16,
  parameter int unsigned STEP_W = 5
) (
  input  logic [POS_W-1:0]  x,
  input  logic [STEP_W-1:0] step,
  input  logic [POS_W-1:0]  finish_x,
  input  logic              advance,
  input  logic              clear,
  output logic [POS_W-1:0]  next_x_c,
  output logic              crossed_c
);

  // One extra bit so x + step can never wrap before the finish compare
  logic [POS_W:0] sum_c;

  assign sum_c     = {1'b0, x} + (POS_W+1)'(step);
  assign crossed_c = advance && (sum_c >= {1'b0, finish_x});

  always_comb begin
    next_x_c = x;
    if (clear)          next_x_c = '0;
    else if (crossed_c) next_x_c = finish_x;
    else if (advance)   next_x_c = sum_c[POS_W-1:0];
  end

endmodule

// File: rtl/race_controller.sv
// Frame-synchronous race sequencer: countdown, car advancement, winner latch, result hold.
// Optional speed jitter from a 16-bit LFSR is enabled by defining RACE_SPEED_JITTER_EN.
module race_controller
  import race_pkg::*;
#(
  parameter int unsigned NUM_CARS     = 6,
  parameter int unsigned POS_W        = 16,
  parameter int unsigned SPEED_W      = 4,
  parameter int unsigned CAR_W        = CAR_W_DEFAULT,
  parameter int unsigned LIGHT_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES  = 300
) (
  input  logic            CLK,
  input  logic            RST_N,
  race_controller_if.slave bus
);

  localparam int unsigned STEP_W     = SPEED_W + 1;
  localparam int unsigned MAX_FRAMES = (LIGHT_FRAMES > HOLD_FRAMES) ? LIGHT_FRAMES : HOLD_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                light_q, light_d;
  logic [WINNER_W-1:0]       winner_q, winner_d, first_c;
  logic                      valid_q, valid_d;
  logic                      tie_q, tie_d;
  logic [NUM_CARS*POS_W-1:0] car_x_q, car_x_d;
  logic [NUM_CARS-1:0]       crossed_c, jitter_c;
  logic [POS_W-1:0]          hres_c, finish_x_c;
  logic                      abort_c, advance_c, clear_c, last_hold_c, multi_c;

  assign hres_c     = POS_W'(bus.H_RES);
  assign finish_x_c = (hres_c > POS_W'(CAR_W)) ? (hres_c - POS_W'(CAR_W)) : '0;

  assign abort_c     = bus.i_abort && (state_q != ST_IDLE);
  assign last_hold_c = (cnt_q == CNT_W'(HOLD_FRAMES - 1));
  assign advance_c   = (state_q == ST_RACE) && bus.i_frame_tick && !bus.i_abort;
  assign clear_c     = abort_c ||
                       ((state_q == ST_FINISH) && bus.i_frame_tick && last_hold_c);

`ifdef RACE_SPEED_JITTER_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance_c) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign jitter_c = lfsr_q[NUM_CARS-1:0];
`else
  assign jitter_c = '0;
`endif

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    logic [STEP_W-1:0] step_c;
    assign step_c = STEP_W'(bus.i_speed[g*SPEED_W +: SPEED_W]) + STEP_W'(jitter_c[g]);

    car_stepper #(
      .POS_W (POS_W),
      .STEP_W(STEP_W)
    ) u_stepper (
      .x        (car_x_q[g*POS_W +: POS_W]),
      .step     (step_c),
      .finish_x (finish_x_c),
      .advance  (advance_c),
      .clear    (clear_c),
      .next_x_c (car_x_d[g*POS_W +: POS_W]),
      .crossed_c(crossed_c[g])
    );
  end

  // Lowest crossed lane wins; more than one set bit means a tie
  always_comb begin
    first_c = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (crossed_c[i]) first_c = WINNER_W'(i);
    end
  end
  assign multi_c = |(crossed_c & (crossed_c - NUM_CARS'(1)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    light_d  = light_q;
    winner_d = winner_q;
    valid_d  = valid_q;
    tie_d    = tie_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          state_d = ST_COUNTDOWN;
          light_d = LIGHT_3;
          cnt_d   = '0;
          valid_d = 1'b0;
          tie_d   = 1'b0;
        end
      end
      ST_COUNTDOWN: begin
        if (bus.i_frame_tick) begin
          if (cnt_q == CNT_W'(LIGHT_FRAMES - 1)) begin
            cnt_d = '0;
            if (light_q == LIGHT_1) begin
              state_d = ST_RACE;
              light_d = LIGHT_OFF;
            end else begin
              light_d = light_q - 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RACE: begin
        if (advance_c && (|crossed_c)) begin
          state_d  = ST_FINISH;
          winner_d = first_c;
          tie_d    = multi_c;
          valid_d  = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_FINISH: begin
        if (bus.i_frame_tick) begin
          if (last_hold_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides any start or tick handling above
    if (abort_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      light_d = LIGHT_OFF;
      valid_d = 1'b0;
      tie_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      light_q  <= LIGHT_OFF;
      winner_q <= '0;
      valid_q  <= 1'b0;
      tie_q    <= 1'b0;
      car_x_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      light_q  <= light_d;
      winner_q <= winner_d;
      valid_q  <= valid_d;
      tie_q    <= tie_d;
      car_x_q  <= car_x_d;
    end
  end

  assign bus.o_state        = state_q;
  assign bus.o_light        = light_q;
  assign bus.o_winner       = winner_q;
  assign bus.o_winner_valid = valid_q;
  assign bus.o_tie          = tie_q;
  assign bus.o_car_x        = car_x_q;

endmodule

// File: tb/tb_race_controller.sv
// Randomised scoreboard bench for race_controller against a frame-level race model.
module tb_race_controller;
  import race_pkg::*;

  localparam int NC = 6;
  localparam int PW = 16;
  localparam int SW = 4;
  localparam int LF = 2;
  localparam int HF = 4;
  localparam int CW = 60;

  typedef struct packed {
    logic [1:0]       st;
    logic [1:0]       light;
    logic [2:0]       win;
    logic             valid;
    logic             tie;
    logic [NC*PW-1:0] x;
  } snap_t;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  race_controller_if #(.NUM_CARS(NC), .POS_W(PW), .SPEED_W(SW)) bus();

  race_controller #(
    .NUM_CARS(NC), .POS_W(PW), .SPEED_W(SW), .CAR_W(CW),
    .LIGHT_FRAMES(LF), .HOLD_FRAMES(HF)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int    n_cmp = 0;
  int    n_fail = 0;
  snap_t exp_q[$];

  int hres;
  int sp[NC];

  // Race model: phase 0..3, tick counts per phase, integer positions
  int          m_phase, m_cd, m_hold, m_win;
  int          m_x[NC];
  bit          m_valid, m_tie;
  logic [15:0] m_lfsr;

  function automatic void model_reset();
    m_phase = 0; m_cd = 0; m_hold = 0; m_win = 0;
    m_valid = 0; m_tie = 0; m_lfsr = LFSR_SEED;
    for (int i = 0; i < NC; i++) m_x[i] = 0;
  endfunction

  function automatic void model_step(input bit tick, input bit start, input bit abort);
    int fx, ncross, step;
    fx = (hres > CW) ? hres - CW : 0;
    if (abort && m_phase != 0) begin
      m_phase = 0; m_valid = 0; m_tie = 0;
      for (int i = 0; i < NC; i++) m_x[i] = 0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin m_phase = 1; m_cd = 0; m_valid = 0; m_tie = 0; end
        1: if (tick) begin m_cd++; if (m_cd == 3*LF) m_phase = 2; end
        2: if (tick) begin
          ncross = 0;
          for (int i = 0; i < NC; i++) begin
            step = sp[i];
`ifdef RACE_SPEED_JITTER_EN
            step = step + int'(m_lfsr[i]);
`endif
            if (m_x[i] + step >= fx) begin
              m_x[i] = fx;
              if (ncross == 0) m_win = i;
              ncross++;
            end else begin
              m_x[i] = m_x[i] + step;
            end
          end
          m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
          if (ncross > 0) begin m_phase = 3; m_hold = 0; m_valid = 1; m_tie = (ncross > 1); end
        end
        default: if (tick) begin
          m_hold++;
          if (m_hold == HF) begin
            m_phase = 0;
            for (int i = 0; i < NC; i++) m_x[i] = 0;
          end
        end
      endcase
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.st    = 2'(m_phase);
    s.light = (m_phase == 1) ? 2'(3 - m_cd / LF) : 2'd0;
    s.win   = 3'(m_win);
    s.valid = m_valid;
    s.tie   = m_tie;
    for (int i = 0; i < NC; i++) s.x[i*PW +: PW] = PW'(m_x[i]);
    return s;
  endfunction

  function automatic longint car_x(input int i);
    logic [NC*PW-1:0] v;
    v = bus.o_car_x;
    return longint'(v[i*PW +: PW]);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit tick, input bit start, input bit abort);
    @(negedge CLK);
    bus.i_frame_tick = tick;
    bus.i_start      = start;
    bus.i_abort      = abort;
    bus.H_RES        = 12'(hres);
    for (int i = 0; i < NC; i++) bus.i_speed[i*SW +: SW] = SW'(sp[i]);
    model_step(tick, start, abort);
    exp_q.push_back(model_snap());
  endtask

  task automatic tick_frame();
    repeat ($urandom_range(0, 2)) cyc(0, 0, 0);
    cyc(1, 0, 0);
  endtask

  task automatic settle();
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, bus.o_state, 0);
    chk({tag, "_light"}, bus.o_light, 0);
    chk({tag, "_winner"}, bus.o_winner, 0);
    chk({tag, "_valid"}, bus.o_winner_valid, 0);
    chk({tag, "_tie"}, bus.o_tie, 0);
    chk({tag, "_x_any"}, |bus.o_car_x, 0);
  endtask

  task automatic async_reset();
    @(posedge CLK); #2;
    bus.i_frame_tick = 0; bus.i_start = 0; bus.i_abort = 0;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Cycle-by-cycle scoreboard: one expected snapshot per driven cycle
  initial begin : monitor
    snap_t e, a;
    forever begin
      @(posedge CLK); #1;
      if (RST_N && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.st = bus.o_state; a.light = bus.o_light; a.win = bus.o_winner;
        a.valid = bus.o_winner_valid; a.tie = bus.o_tie; a.x = bus.o_car_x;
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL sb_cycle t=%0t st/light/win/valid/tie got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d x got %h want %h",
                   $time, a.st, a.light, a.win, a.valid, a.tie,
                   e.st, e.light, e.win, e.valid, e.tie, a.x, e.x);
        end
      end
    end
  end

`ifndef RACE_SPEED_JITTER_EN
  task automatic directed();
    hres = 640; sp = '{1, 1, 5, 1, 1, 1};
    cyc(1, 1, 0); settle();
    chk("cd_start_state", bus.o_state, 1);
    chk("cd_start_light", bus.o_light, 3);
    tick_frame(); settle(); chk("cd_t1_light", bus.o_light, 3);
    tick_frame(); settle(); chk("cd_t2_light", bus.o_light, 2);
    repeat (2) tick_frame(); settle(); chk("cd_t4_light", bus.o_light, 1);
    repeat (2) tick_frame(); settle();
    chk("cd_t6_state", bus.o_state, 2);
    chk("cd_t6_light", bus.o_light, 0);
    chk("cd_no_motion", |bus.o_car_x, 0);
    repeat (115) tick_frame(); settle();
    chk("win_pre_state", bus.o_state, 2);
    chk("win_pre_x2", car_x(2), 575);
    tick_frame(); settle();
    chk("win_state", bus.o_state, 3);
    chk("win_winner", bus.o_winner, 2);
    chk("win_tie", bus.o_tie, 0);
    chk("win_valid", bus.o_winner_valid, 1);
    chk("win_x2", car_x(2), 580);
    chk("win_x0", car_x(0), 116);
    chk("win_x5", car_x(5), 116);
    repeat (3) tick_frame(); settle();
    chk("hold_state", bus.o_state, 3);
    chk("hold_x2", car_x(2), 580);
    tick_frame(); settle();
    chk("post_state", bus.o_state, 0);
    chk("post_x_any", |bus.o_car_x, 0);
    chk("post_valid", bus.o_winner_valid, 1);
    chk("post_winner", bus.o_winner, 2);

    sp = '{10, 1, 1, 10, 1, 1};
    cyc(0, 1, 0); settle();
    chk("tie_start_valid", bus.o_winner_valid, 0);
    chk("tie_start_state", bus.o_state, 1);
    repeat (6 + 57) tick_frame(); settle();
    chk("tie_pre_x0", car_x(0), 570);
    tick_frame(); settle();
    chk("tie_winner", bus.o_winner, 0);
    chk("tie_tie", bus.o_tie, 1);
    chk("tie_x0", car_x(0), 580);
    chk("tie_x3", car_x(3), 580);
    chk("tie_x1", car_x(1), 58);
    repeat (4) tick_frame(); settle();
    chk("tie_idle", bus.o_state, 0);

    cyc(0, 1, 0);
    repeat (6 + 19) tick_frame(); settle();
    chk("abort_pre_x0", car_x(0), 190);
    cyc(1, 0, 1); settle();
    chk("abort_state", bus.o_state, 0);
    chk("abort_x_any", |bus.o_car_x, 0);
    chk("abort_valid", bus.o_winner_valid, 0);
    chk("abort_light", bus.o_light, 0);
    cyc(0, 1, 1); settle();
    chk("abort_start_state", bus.o_state, 0);

    hres = 50; sp = '{0, 0, 0, 0, 0, 0};
    cyc(0, 1, 0);
    repeat (6) tick_frame(); settle();
    chk("narrow_race", bus.o_state, 2);
    tick_frame(); settle();
    chk("narrow_state", bus.o_state, 3);
    chk("narrow_winner", bus.o_winner, 0);
    chk("narrow_tie", bus.o_tie, 1);
    chk("narrow_x_any", |bus.o_car_x, 0);
    repeat (4) tick_frame();

    hres = 4095; sp = '{15, 15, 15, 15, 15, 15};
    cyc(0, 1, 0);
    repeat (6 + 268) tick_frame(); settle();
    chk("sat_pre_x0", car_x(0), 4020);
    tick_frame(); settle();
    chk("sat_x0", car_x(0), 4035);
    chk("sat_x5", car_x(5), 4035);
    chk("sat_state", bus.o_state, 3);
    chk("sat_tie", bus.o_tie, 1);
    repeat (4) tick_frame(); settle();
    chk("sat_idle", bus.o_state, 0);
  endtask
`endif

  // All-zero speeds: static without jitter, LFSR-driven with it
  task automatic speed0_run();
    hres = 640; sp = '{0, 0, 0, 0, 0, 0};
    cyc(0, 1, 0);
    repeat (6 + 30) tick_frame();
`ifndef RACE_SPEED_JITTER_EN
    settle();
    chk("speed0_state", bus.o_state, 2);
    chk("speed0_x_any", |bus.o_car_x, 0);
`endif
    cyc(0, 0, 1);
  endtask

  task automatic random_race(input bit vary, input bit do_reset);
    int n, r;
    hres = $urandom_range(100, 900);
    for (int i = 0; i < NC; i++) sp[i] = $urandom_range(0, 15);
    sp[$urandom_range(0, NC-1)] = $urandom_range(1, 15);
    cyc(0, 1, 0);
    n = 0;
    while (m_phase != 0 && n < 3000) begin
      r = $urandom_range(0, 199);
      if (vary && m_phase == 2 && r < 20) sp[$urandom_range(0, NC-1)] = $urandom_range(1, 15);
      if (r == 0)                                   cyc(0, 0, 1);
      else if (r < 6)                               cyc(0, 1, 0);
      else if (do_reset && m_phase == 2 && r < 8)   async_reset();
      else                                          tick_frame();
      n++;
    end
    if (m_phase != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL random_race_bound: race still in phase %0d after %0d steps", m_phase, n);
    end
  endtask

  initial begin : main
    bus.i_frame_tick = 0; bus.i_start = 0; bus.i_abort = 0;
    bus.H_RES = 12'd640; bus.i_speed = '0;
    hres = 640; sp = '{0, 0, 0, 0, 0, 0};
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #2;
    check_reset_outputs("por");
    model_reset();
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;

`ifndef RACE_SPEED_JITTER_EN
    directed();
`endif
    speed0_run();
    async_reset();
    speed0_run();

    for (int k = 0; k < 8; k++) random_race(k[0], k == 5);

    cyc(0, 0, 0);
    settle();
    repeat (2) @(posedge CLK);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected snapshots left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Sequences the six-lane car race display: start countdown, per-frame car advancement, finish-line detection, winner latch, result hold.
- Drives car X positions into the pixel renderer, replacing the free-running per-car pulse generators.
- Advances only on a one-cycle frame tick from the video timing block, so motion is frame-synchronous.

Parameters:
- NUM_CARS, 6, number of cars and lanes (max 8).
- POS_W, 16, car X position width.
- SPEED_W, 4, per-car speed field width, in pixels per frame.
- CAR_W, 60, car sprite width used to place the finish line.
- LIGHT_FRAMES, 60, frames per countdown light.
- HOLD_FRAMES, 300, frames the result is held before returning to IDLE.

Ports:
- CLK  in  1  system/pixel clock
- RST_N  in  1  asynchronous active-low reset
- i_frame_tick  in  1  one-cycle pulse per frame
- i_start  in  1  start request (level or pulse)
- i_abort  in  1  abort request
- H_RES  in  12  horizontal resolution
- i_speed  in  NUM_CARS*SPEED_W  packed speeds; car i in bits [i*SPEED_W +: SPEED_W]
- o_car_x  out  NUM_CARS*POS_W  packed car X positions
- o_state  out  2  0=IDLE 1=COUNTDOWN 2=RACE 3=FINISH
- o_light  out  2  countdown light: 3,2,1, else 0
- o_winner  out  3  winning car index
- o_winner_valid  out  1  winner latched
- o_tie  out  1  more than one car crossed on the winning tick

Behaviour:
- Reset: all outputs 0; state IDLE; positions 0; counters 0.
- finish_x = (H_RES > CAR_W) ? H_RES-CAR_W : 0, zero-extended to POS_W.
- IDLE:
  - Positions held at 0.
  - i_start=1 → COUNTDOWN next cycle; o_light=3; frame counter=0; o_winner_valid and o_tie cleared.
  - A frame tick in the same cycle as the start is not counted.
- COUNTDOWN:
  - Each frame tick increments the frame counter.
  - When the counter reaches LIGHT_FRAMES-1 on a tick, the counter resets and o_light decrements.
  - Light 1 expiring → RACE, o_light=0.
  - Total duration is exactly 3*LIGHT_FRAMES ticks.
- RACE, on each frame tick, per car:
  - sum = x + speed, computed in POS_W+1 bits.
  - If sum >= finish_x: x <= finish_x and crossed[i]=1. Otherwise x <= sum.
  - If any crossed[i]: o_winner = lowest crossed index; o_tie = popcount(crossed) > 1; o_winner_valid=1; → FINISH in the same update; counter=0.
  - Speed 0: car never moves.
  - Speeds are sampled on each tick, so a change mid-race takes effect on the next tick.
- FINISH:
  - Positions and winner frozen.
  - After HOLD_FRAMES ticks → IDLE.
  - Positions reset to 0 on IDLE entry; winner outputs stay valid until the next start.
- i_abort (any non-IDLE state): next cycle IDLE; positions 0; o_light=0; o_winner_valid=0; o_tie=0. Abort has priority over start and tick.
- i_start is ignored outside IDLE.
- Latency: position update visible on o_car_x one cycle after the tick.
- Reset mid-operation: immediate, asynchronous return to the reset state.
- No wrap-around: positions saturate at finish_x.

Optional Feature:
- Macro RACE_SPEED_JITTER_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 at reset.
  - Steps once per frame tick in RACE.
  - Car i step = speed + lfsr[i], so a speed-0 car may still move.
- Undefined: LFSR absent; step = speed exactly; motion fully deterministic.

Decomposition:
- Package race_pkg:
  - state encoding (IDLE/COUNTDOWN/RACE/FINISH);
  - CAR_W default;
  - light encoding;
  - LFSR seed/taps.
- Sub-module car_stepper, instantiated NUM_CARS times. Inputs: x, step, finish_x, advance, clear. Outputs: next x, crossed flag.
- Top level owns the FSM, frame counter and winner priority encoder.

Test Plan (all with H_RES=640 → finish_x=580, LIGHT_FRAMES=2, HOLD_FRAMES=4, jitter off unless noted):
- Countdown: start pulse → o_light 3,2,1 each for 2 ticks; RACE after the 6th tick; no car moves during COUNTDOWN.
- Single winner: speeds {1,1,5,1,1,1} → car2 reaches 580 on race tick 116 (others at 116); o_winner=2, o_tie=0; IDLE 4 ticks later, positions 0.
- Tie: speeds {10,1,1,10,1,1} → tick 58: o_winner=0, o_tie=1, cars 0 and 3 at 580.
- Abort: same speeds as the tie case, i_abort at race tick 20 → IDLE next cycle; all x=0; winner_valid=0. i_start with i_abort in the same cycle → stays IDLE.
- Boundary: H_RES=50 (<CAR_W), all speeds 0 → first race tick: all cross, o_winner=0, o_tie=1. Also: speeds 15 with H_RES=4095 → saturates at 4035, no overflow.
- Jitter (RACE_SPEED_JITTER_EN): all speeds 0 → positions follow LFSR bits from seed ACE1; reset reproduces the identical sequence.
